// File: rtl/risc_toy_pkg.sv
// Shared RISC_TOY pipeline definitions: datapath widths, data-memory
// direction encodings, MEM-stage FSM states and the EX/MEM and MEM/WB
// bundle layouts used by the EX, MEM and WB stages.
package risc_toy_pkg;

  localparam int unsigned XLEN  = 32;  // datapath width
  localparam int unsigned RAW   = 5;   // register address width
  localparam int unsigned AW    = 30;  // data-memory word address width
  localparam int unsigned CNT_W = 3;   // load-latency counter width

  localparam logic DRW_RD = 1'b0;
  localparam logic DRW_WR = 1'b1;

  typedef enum logic {
    StRun  = 1'b0,
    StWait = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] st_data;
    logic [RAW-1:0]  rd;
    logic            we;
    logic            ld;
    logic            st;
  } ex_mem_t;

  typedef struct packed {
    logic            valid;
    logic            we;
    logic [RAW-1:0]  rd;
    logic [XLEN-1:0] data;
  } mem_wb_t;

endpackage

// File: rtl/mem_ld_timer.sv
// Load-latency timer for the MEM stage.
//   clk_i, rst_ni  : clock, synchronous active-low reset
//   start_i        : load the counter with load_val_i (read request issued)
//   load_val_i     : read latency in cycles
//   last_o         : counter is 1, i.e. read data is valid this cycle
// The counter free-runs down to 0 and parks there until the next start.
module mem_ld_timer #(
  parameter int unsigned CntW = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [CntW-1:0] load_val_i,
  output logic            last_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CntW'(1));

endmodule

// File: rtl/risc_toy_mem_stage.sv
// RISC_TOY memory-access stage.
//   CLK, RSTN          : clock, synchronous active-low reset
//   ex_*               : EX/MEM bundle from the execute stage
//   mem_stall          : upstream must hold ex_* and everything behind it
//   DREQ/DRW/DADDR/DWDATA/DRDATA : data-memory port (fixed read latency RD_LAT)
//   fwd_*              : same-cycle forwarding of a held non-load result
//   wb_*               : registered MEM/WB bundle
module risc_toy_mem_stage
  import risc_toy_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_result,
  input  logic [XLEN-1:0] ex_st_data,
  input  logic [RAW-1:0]  ex_rd,
  input  logic            ex_we,
  input  logic            ex_ld,
  input  logic            ex_st,
  output logic            mem_stall,
  output logic            DREQ,
  output logic            DRW,
  output logic [AW-1:0]   DADDR,
  output logic [XLEN-1:0] DWDATA,
  input  logic [XLEN-1:0] DRDATA,
  output logic            fwd_en,
  output logic [RAW-1:0]  fwd_rd,
  output logic [XLEN-1:0] fwd_data,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [RAW-1:0]  wb_rd,
  output logic [XLEN-1:0] wb_data
);

  localparam logic [CNT_W-1:0] LdLat = CNT_W'(RD_LAT);

  ex_mem_t    m_q, m_d;
  mem_wb_t    wb_q, wb_d;
  mem_state_e state_q, state_d;
  logic       ld_start;
  logic       ld_last;
  logic       complete;

  mem_ld_timer #(
    .CntW(CNT_W)
  ) u_ld_timer (
    .clk_i      (CLK),
    .rst_ni     (RSTN),
    .start_i    (ld_start),
    .load_val_i (LdLat),
    .last_o     (ld_last)
  );

  always_comb begin
    state_d   = state_q;
    DREQ      = 1'b0;
    DRW       = DRW_RD;
    mem_stall = 1'b0;
    ld_start  = 1'b0;
    complete  = 1'b0;
    wb_d      = wb_q;
    wb_d.valid = 1'b0;

    unique case (state_q)
      StRun: begin
        if (m_q.valid) begin
          if (m_q.ld) begin
            DREQ      = 1'b1;
            mem_stall = 1'b1;
            ld_start  = 1'b1;
            state_d   = StWait;
          end else begin
            DREQ      = m_q.st;
            DRW       = m_q.st ? DRW_WR : DRW_RD;
            complete  = 1'b1;
            wb_d.data = m_q.result;
          end
        end
      end
      StWait: begin
        if (ld_last) begin
          // Data arrives this cycle; release the stall so the next
          // instruction enters on the same edge the load retires.
          state_d   = StRun;
          complete  = 1'b1;
          wb_d.data = DRDATA;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase

    if (complete) begin
      wb_d.valid = 1'b1;
      wb_d.we    = m_q.we & ~m_q.st;
      wb_d.rd    = m_q.rd;
    end
  end

  always_comb begin
    m_d = m_q;
    if (!mem_stall) begin
      m_d.valid   = ex_valid;
      m_d.result  = ex_result;
      m_d.st_data = ex_st_data;
      m_d.rd      = ex_rd;
      m_d.we      = ex_we;
      m_d.ld      = ex_ld;
      m_d.st      = ex_st & ~ex_ld;  // load wins, store dropped
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= StRun;
      m_q     <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      wb_q    <= wb_d;
    end
  end

  assign DADDR    = m_q.result[XLEN-1:2];
  assign DWDATA   = m_q.st_data;
  assign fwd_en   = m_q.valid & m_q.we & ~m_q.ld & ~m_q.st & (state_q == StRun);
  assign fwd_rd   = m_q.rd;
  assign fwd_data = m_q.result;
  assign wb_valid = wb_q.valid;
  assign wb_we    = wb_q.we;
  assign wb_rd    = wb_q.rd;
  assign wb_data  = wb_q.data;

endmodule

// File: tb/tb_risc_toy_mem_stage.sv
module tb_risc_toy_mem_stage;

  logic        clk;
  logic        rstn;
  logic        ex_valid;
  logic [31:0] ex_result;
  logic [31:0] ex_st_data;
  logic [4:0]  ex_rd;
  logic        ex_we;
  logic        ex_ld;
  logic        ex_st;

  // RD_LAT = 1 instance
  logic        stall1, dreq1, drw1, fwd_en1, wbv1, wbwe1;
  logic [29:0] daddr1;
  logic [31:0] dwdata1, drdata1, fwd_data1, wb_data1;
  logic [4:0]  fwd_rd1, wb_rd1;
  // RD_LAT = 3 instance
  logic        stall3, dreq3, drw3, fwd_en3, wbv3, wbwe3;
  logic [29:0] daddr3;
  logic [31:0] dwdata3, drdata3, fwd_data3, wb_data3;
  logic [4:0]  fwd_rd3, wb_rd3;

  logic [29:0] last_addr1, last_addr3;
  int          n_vec, n_err, wr_count1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    if (a == 30'h80) return 32'h1234_5678;
    return {2'b00, a} ^ 32'hCAFE_0000;
  endfunction

  // Memory model: address captured at the edge closing the request cycle.
  always @(posedge clk) begin
    if (dreq1 && !drw1) last_addr1 <= daddr1;
    if (dreq3 && !drw3) last_addr3 <= daddr3;
  end
  assign drdata1 = mem_word(last_addr1);
  assign drdata3 = mem_word(last_addr3);

  always @(negedge clk) if (dreq1 && drw1) wr_count1++;

  risc_toy_mem_stage #(.RD_LAT(1)) u_dut1 (
    .CLK(clk), .RSTN(rstn), .ex_valid(ex_valid), .ex_result(ex_result),
    .ex_st_data(ex_st_data), .ex_rd(ex_rd), .ex_we(ex_we), .ex_ld(ex_ld), .ex_st(ex_st),
    .mem_stall(stall1), .DREQ(dreq1), .DRW(drw1), .DADDR(daddr1), .DWDATA(dwdata1),
    .DRDATA(drdata1), .fwd_en(fwd_en1), .fwd_rd(fwd_rd1), .fwd_data(fwd_data1),
    .wb_valid(wbv1), .wb_we(wbwe1), .wb_rd(wb_rd1), .wb_data(wb_data1)
  );

  risc_toy_mem_stage #(.RD_LAT(3)) u_dut3 (
    .CLK(clk), .RSTN(rstn), .ex_valid(ex_valid), .ex_result(ex_result),
    .ex_st_data(ex_st_data), .ex_rd(ex_rd), .ex_we(ex_we), .ex_ld(ex_ld), .ex_st(ex_st),
    .mem_stall(stall3), .DREQ(dreq3), .DRW(drw3), .DADDR(daddr3), .DWDATA(dwdata3),
    .DRDATA(drdata3), .fwd_en(fwd_en3), .fwd_rd(fwd_rd3), .fwd_data(fwd_data3),
    .wb_valid(wbv3), .wb_we(wbwe3), .wb_rd(wb_rd3), .wb_data(wb_data3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic v, input logic [31:0] res, input logic [31:0] sd,
                          input logic [4:0] rd, input logic we, input logic ld,
                          input logic st);
    ex_valid = v; ex_result = res; ex_st_data = sd; ex_rd = rd;
    ex_we = we; ex_ld = ld; ex_st = st;
  endtask

  task automatic drive_idle();
    drive_op(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    drive_idle();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if ({dreq1, drw1, stall1, fwd_en1, wbv1} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl1: got %b expected 00000", {dreq1, drw1, stall1, fwd_en1, wbv1});
    end
    n_vec++;
    if ({daddr1, dwdata1, wb_data1} !== 94'h0) begin
      n_err++;
      $display("FAIL reset_data1: daddr %h dwdata %h wb_data %h expected all zero",
               daddr1, dwdata1, wb_data1);
    end
    n_vec++;
    if ({dreq3, drw3, stall3, fwd_en3, wbv3} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl3: got %b expected 00000", {dreq3, drw3, stall3, fwd_en3, wbv3});
    end
  endtask

  task automatic test_alu();
    apply_reset();
    drive_op(1'b1, 32'h0000_0010, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    n_vec++;
    if ({dreq1, stall1, fwd_en1, fwd_rd1, fwd_data1} !== {1'b0, 1'b0, 1'b1, 5'd3, 32'h10}) begin
      n_err++;
      $display("FAIL alu_fwd: dreq %b stall %b fwd_en %b rd %0d data %h expected 0 0 1 3 00000010",
               dreq1, stall1, fwd_en1, fwd_rd1, fwd_data1);
    end
    // Second ALU op back-to-back, no writeback enable: must not forward.
    drive_op(1'b1, 32'h0000_0020, 32'h0, 5'd6, 1'b0, 1'b0, 1'b0);
    tick();
    n_vec++;
    if ({wbv1, wbwe1, wb_rd1, wb_data1} !== {1'b1, 1'b1, 5'd3, 32'h10}) begin
      n_err++;
      $display("FAIL alu_wb1: v %b we %b rd %0d data %h expected 1 1 3 00000010",
               wbv1, wbwe1, wb_rd1, wb_data1);
    end
    n_vec++;
    if (fwd_en1 !== 1'b0) begin
      n_err++;
      $display("FAIL alu_nofwd_we0: fwd_en %b expected 0", fwd_en1);
    end
    drive_idle();
    tick();
    n_vec++;
    if ({wbv1, wbwe1, wb_rd1, wb_data1} !== {1'b1, 1'b0, 5'd6, 32'h20}) begin
      n_err++;
      $display("FAIL alu_wb2: v %b we %b rd %0d data %h expected 1 0 6 00000020",
               wbv1, wbwe1, wb_rd1, wb_data1);
    end
    tick();
    n_vec++;
    if ({wbv1, wb_data1} !== {1'b0, 32'h20}) begin
      n_err++;
      $display("FAIL alu_wb_hold: v %b data %h expected 0 00000020", wbv1, wb_data1);
    end
  endtask

  task automatic test_store();
    apply_reset();
    drive_op(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 5'd7, 1'b1, 1'b0, 1'b1);
    tick();
    n_vec++;
    if ({dreq1, drw1, stall1, fwd_en1, daddr1, dwdata1} !==
        {1'b1, 1'b1, 1'b0, 1'b0, 30'h41, 32'hDEAD_BEEF}) begin
      n_err++;
      $display("FAIL store_port: req %b rw %b stall %b fwd %b addr %h wdata %h expected 1 1 0 0 41 deadbeef",
               dreq1, drw1, stall1, fwd_en1, daddr1, dwdata1);
    end
    drive_idle();
    tick();
    n_vec++;
    if ({dreq1, wbv1, wbwe1, wb_rd1} !== {1'b0, 1'b1, 1'b0, 5'd7}) begin
      n_err++;
      $display("FAIL store_wb: req %b v %b we %b rd %0d expected 0 1 0 7",
               dreq1, wbv1, wbwe1, wb_rd1);
    end
  endtask

  task automatic test_load_lat1();
    apply_reset();
    drive_op(1'b1, 32'h0000_0200, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    n_vec++;
    if ({dreq1, drw1, stall1, fwd_en1, wbv1, daddr1} !==
        {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 30'h80}) begin
      n_err++;
      $display("FAIL ld1_req: req %b rw %b stall %b fwd %b wbv %b addr %h expected 1 0 1 0 0 80",
               dreq1, drw1, stall1, fwd_en1, wbv1, daddr1);
    end
    tick();  // inputs held across the stalled edge
    n_vec++;
    if ({dreq1, stall1, wbv1} !== 3'b000) begin
      n_err++;
      $display("FAIL ld1_wait: req %b stall %b wbv %b expected 0 0 0", dreq1, stall1, wbv1);
    end
    drive_idle();
    tick();
    n_vec++;
    if ({wbv1, wbwe1, wb_rd1, wb_data1} !== {1'b1, 1'b1, 5'd5, 32'h1234_5678}) begin
      n_err++;
      $display("FAIL ld1_wb: v %b we %b rd %0d data %h expected 1 1 5 12345678",
               wbv1, wbwe1, wb_rd1, wb_data1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] op_res [3];
    logic [4:0]  op_rd  [3];
    logic        op_ld  [3];
    logic [4:0]  exp_rd [3];
    logic [31:0] exp_dt [3];
    int idx, n_req, n_stall, n_wb, req_at0, req_at1;
    logic s_stall, s_req, s_wbv;
    logic [4:0]  s_rd;
    logic [31:0] s_dt;
    op_res = '{32'h0000_0300, 32'h0000_0404, 32'h0000_0055};
    op_rd  = '{5'd1, 5'd2, 5'd3};
    op_ld  = '{1'b1, 1'b1, 1'b0};
    exp_rd = '{5'd1, 5'd2, 5'd3};
    exp_dt = '{32'hCAFE_00C0, 32'hCAFE_0101, 32'h0000_0055};
    n_req = 0; n_stall = 0; n_wb = 0; req_at0 = -1; req_at1 = -1;
    apply_reset();
    idx = 0;
    drive_op(1'b1, op_res[0], 32'h0, op_rd[0], 1'b1, op_ld[0], 1'b0);
    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
      s_stall = stall3; s_req = dreq3; s_wbv = wbv3; s_rd = wb_rd3; s_dt = wb_data3;
      if (s_stall) n_stall++;
      if (s_req) begin
        if (n_req == 0) req_at0 = n;
        else if (n_req == 1) req_at1 = n;
        n_req++;
      end
      if (s_wbv) begin
        if (n_wb < 3) begin
          n_vec++;
          if ({s_rd, s_dt} !== {exp_rd[n_wb], exp_dt[n_wb]}) begin
            n_err++;
            $display("FAIL b2b_wb%0d: rd %0d data %h expected %0d %h",
                     n_wb, s_rd, s_dt, exp_rd[n_wb], exp_dt[n_wb]);
          end
        end
        n_wb++;
      end
      @(posedge clk);
      #1;
      if (!s_stall) begin
        idx++;
        if (idx < 3) drive_op(1'b1, op_res[idx], 32'h0, op_rd[idx], 1'b1, op_ld[idx], 1'b0);
        else drive_idle();
      end
    end
    n_vec++;
    if (n_req !== 2 || (req_at1 - req_at0) !== 4) begin
      n_err++;
      $display("FAIL b2b_dreq: pulses %0d spacing %0d expected 2 4", n_req, req_at1 - req_at0);
    end
    n_vec++;
    if (n_stall !== 6) begin
      n_err++;
      $display("FAIL b2b_stall: stall cycles %0d expected 6", n_stall);
    end
    n_vec++;
    if (n_wb !== 3) begin
      n_err++;
      $display("FAIL b2b_wbcount: wb pulses %0d expected 3", n_wb);
    end
  endtask

  task automatic test_reset_in_wait();
    apply_reset();
    drive_op(1'b1, 32'h0000_0208, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0);
    tick();
    tick();  // now in WAIT, cnt = 3
    n_vec++;
    if ({dreq3, stall3} !== 2'b01) begin
      n_err++;
      $display("FAIL rstw_inwait: req %b stall %b expected 0 1", dreq3, stall3);
    end
    rstn = 1'b0;
    drive_idle();
    tick();
    rstn = 1'b1;
    n_vec++;
    if ({dreq3, drw3, stall3, fwd_en3, wbv3, daddr3, dwdata3, wb_data3} !== 99'h0) begin
      n_err++;
      $display("FAIL rstw_outputs: req %b rw %b stall %b fwd %b wbv %b addr %h wd %h wbd %h expected all zero",
               dreq3, drw3, stall3, fwd_en3, wbv3, daddr3, dwdata3, wb_data3);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if (wbv3 !== 1'b0) begin
        n_err++;
        $display("FAIL rstw_late_data: cycle %0d wb_valid %b expected 0", i, wbv3);
      end
    end
  endtask

  task automatic test_ld_st_both();
    apply_reset();
    wr_count1 = 0;
    // Low address bits are ignored: 0x43 maps to word 0x10.
    drive_op(1'b1, 32'h0000_0043, 32'h0000_0BAD, 5'd4, 1'b1, 1'b1, 1'b1);
    tick();
    n_vec++;
    if ({dreq1, drw1, stall1, daddr1} !== {1'b1, 1'b0, 1'b1, 30'h10}) begin
      n_err++;
      $display("FAIL ldst_req: req %b rw %b stall %b addr %h expected 1 0 1 10",
               dreq1, drw1, stall1, daddr1);
    end
    tick();
    drive_idle();
    tick();
    n_vec++;
    if ({wbv1, wbwe1, wb_rd1, wb_data1} !== {1'b1, 1'b1, 5'd4, 32'hCAFE_0010}) begin
      n_err++;
      $display("FAIL ldst_wb: v %b we %b rd %0d data %h expected 1 1 4 cafe0010",
               wbv1, wbwe1, wb_rd1, wb_data1);
    end
    tick();
    tick();
    n_vec++;
    if (wr_count1 !== 0) begin
      n_err++;
      $display("FAIL ldst_nowrite: write cycles %0d expected 0", wr_count1);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    wr_count1 = 0;
    last_addr1 = '0;
    last_addr3 = '0;
    rstn = 1'b0;
    drive_idle();
    test_reset();
    test_alu();
    test_store();
    test_load_lat1();
    test_back_to_back();
    test_reset_in_wait();
    test_ld_st_both();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
